// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl
// Program counter and two-level return stack for a four-phase (Q1..Q4)
// baseline PIC-style core. The PC advances on Q1. Control events are
// evaluated on Q4. Every taken branch, return, PCL write or skip forces
// the following instruction slot to execute as a NOP.
//
// Handshake note: this block has no valid/ready handshakes. Its inputs are
// level-qualified by the phase value. instIn must be stable Q1..Q4.
// skipReq and pclWrite are only looked at on a Q4 clock.

module pc_stack_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  phase,
    input  logic [11:0] instIn,
    input  logic        skipReq,
    input  logic        pclWrite,
    input  logic [7:0]  pclData,
    input  logic [1:0]  statusPA,
    output logic [10:0] pcOut,
    output logic        flushOut,
    output logic [1:0]  stkDepth,
    output logic        stkOvf,
    output logic        stkUnf
);

    localparam logic [1:0]  PH_Q1      = 2'd0;
    localparam logic [1:0]  PH_Q4      = 2'd3;
    localparam logic [10:0] PC_RESET   = 11'h7FF;
    localparam logic [1:0]  DEPTH_FULL = 2'd2;
    localparam logic [1:0]  DEPTH_NONE = 2'd0;

    // Control event selected for the current Q4. The list is in priority
    // order. Branch-type instructions win over the ALU-side requests.
    typedef enum logic [2:0] {
        EV_NONE = 3'd0,
        EV_GOTO = 3'd1,
        EV_CALL = 3'd2,
        EV_RET  = 3'd3,
        EV_PCL  = 3'd4,
        EV_SKIP = 3'd5
    } event_t;

    // Architectural state
    logic [10:0] r_pc;
    logic [10:0] r_stk1;
    logic [10:0] r_stk2;
    logic [1:0]  r_depth;
    logic        r_flush;
    logic        r_ovf;
    logic        r_unf;

    // Decoded event and candidate PC values
    event_t      w_event;
    logic [10:0] w_pc_inc;
    logic [10:0] w_goto_target;
    logic [10:0] w_call_target;
    logic [10:0] w_pcl_target;
    logic        w_stk_full;
    logic        w_stk_empty;

    // Branch targets. CALL and PCL writes can only reach the lower half of
    // a 512-word page, because bit 8 is forced to zero.
    always_comb begin
        w_pc_inc      = r_pc + 11'd1;
        w_goto_target = {statusPA, instIn[8:0]};
        w_call_target = {statusPA, 1'b0, instIn[7:0]};
        w_pcl_target  = {statusPA, 1'b0, pclData};
        w_stk_full    = (r_depth == DEPTH_FULL);
        w_stk_empty   = (r_depth == DEPTH_NONE);
    end

    // Priority decode of the single event that a non-flushed Q4 applies.
    always_comb begin
        w_event = EV_NONE;
        if (instIn[11:9] == 3'b101) begin
            w_event = EV_GOTO;
        end else if (instIn[11:8] == 4'b1001) begin
            w_event = EV_CALL;
        end else if (instIn[11:8] == 4'b1000) begin
            w_event = EV_RET;
        end else if (pclWrite) begin
            w_event = EV_PCL;
        end else if (skipReq) begin
            w_event = EV_SKIP;
        end
    end

    // PC, stack and flag registers.
    // Q1 increments the PC.
    // Q4 applies one event, or retires a flushed slot.
    // Q2 and Q3 hold all state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_RESET;
            r_stk1  <= 11'd0;
            r_stk2  <= 11'd0;
            r_depth <= DEPTH_NONE;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (phase == PH_Q1) begin
            r_pc <= w_pc_inc;
        end else if (phase == PH_Q4) begin
            if (r_flush) begin
                // The killed instruction has no side effects. It only
                // closes the flushed slot.
                r_flush <= 1'b0;
            end else begin
                case (w_event)
                    EV_GOTO: begin
                        r_pc    <= w_goto_target;
                        r_flush <= 1'b1;
                    end
                    EV_CALL: begin
                        // r_pc already holds the return address, because
                        // it was incremented at Q1.
                        r_stk1  <= r_pc;
                        r_stk2  <= r_stk1;
                        r_pc    <= w_call_target;
                        r_flush <= 1'b1;
                        if (w_stk_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_depth <= r_depth + 2'd1;
                        end
                    end
                    EV_RET: begin
                        // An underflowing pop still loads whatever stk1
                        // holds.
                        r_pc    <= r_stk1;
                        r_stk1  <= r_stk2;
                        r_flush <= 1'b1;
                        if (w_stk_empty) begin
                            r_unf <= 1'b1;
                        end else begin
                            r_depth <= r_depth - 2'd1;
                        end
                    end
                    EV_PCL: begin
                        r_pc    <= w_pcl_target;
                        r_flush <= 1'b1;
                    end
                    EV_SKIP: begin
                        r_flush <= 1'b1;
                    end
                    default: begin
                        r_flush <= 1'b0;
                    end
                endcase
            end
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        pcOut    = r_pc;
        flushOut = r_flush;
        stkDepth = r_depth;
        stkOvf   = r_ovf;
        stkUnf   = r_unf;
    end

endmodule

// File: doc/pc_stack_ctrl.md
PC_STACK_CTRL -- requirements
Module: pc_stack_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port phase  input  2  Q-phase of current clock: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
REQ-004 SHALL have port instIn  input  12  instruction currently executing, stable Q1..Q4.
REQ-005 SHALL have port skipReq  input  1  skip condition from ALU (FSZ zero / BTFSx true), qualified at Q4 only.
REQ-006 SHALL have port pclWrite  input  1  ALU result targets PCL, qualified at Q4 only.
REQ-007 SHALL have port pclData  input  8  value written to PCL.
REQ-008 SHALL have port statusPA  input  2  page-select bits STATUS[6:5].
REQ-009 SHALL have port pcOut  output  11  program counter, direct from register.
REQ-010 SHALL have port flushOut  output  1  high for whole instruction cycle whose instruction is forced to NOP.
REQ-011 SHALL have port stkDepth  output  2  stack occupancy, 0..2.
REQ-012 SHALL have port stkOvf  output  1  sticky: push attempted at depth 2.
REQ-013 SHALL have port stkUnf  output  1  sticky: pop attempted at depth 0.

Function
REQ-014 SHALL increment pc by 1 modulo 2048 on every clock with phase==Q1 (11'h7FF -> 11'h000).
REQ-015 SHALL evaluate control events only on clock with phase==Q4; Q2/Q3 leave all state unchanged.
REQ-016 At Q4 with flushOut==1: current instruction is killed; no PC load, no push/pop, skipReq/pclWrite ignored; flushOut<=0.
REQ-017 At Q4 with flushOut==0, SHALL apply first matching event in priority order (REQ-018..REQ-022), at most one per Q4.
REQ-018 GOTO (instIn[11:9]==3'b101): pc<={statusPA, instIn[8:0]}; flushOut<=1.
REQ-019 CALL (instIn[11:8]==4'b1001): push pc; pc<={statusPA, 1'b0, instIn[7:0]}; flushOut<=1.
REQ-020 RETLW (instIn[11:8]==4'b1000): pop into pc; flushOut<=1.
REQ-021 pclWrite==1: pc<={statusPA, 1'b0, pclData}; flushOut<=1.
REQ-022 skipReq==1: pc unchanged; flushOut<=1.
REQ-023 No event: flushOut<=0; pc unchanged.
REQ-024 Stack: two 11-bit registers stk1 (top), stk2.
REQ-025 Push: stk2<=stk1, stk1<=pc (already-incremented return address); stkDepth<=min(stkDepth+1,2).
REQ-026 Push at stkDepth==2: stk2 content lost, push still performed, stkOvf<=1, stkDepth stays 2.
REQ-027 Pop: pc<=stk1, stk1<=stk2, stk2 unchanged; stkDepth<=stkDepth-1.
REQ-028 Pop at stkDepth==0: pop still performed (stale value), stkUnf<=1, stkDepth stays 0.
REQ-029 stkOvf/stkUnf, once set, SHALL remain 1 until rst.
REQ-030 Branch events take priority over pclWrite and skipReq asserted in same Q4.
REQ-031 pcOut SHALL reflect new value the clock after the updating Q1/Q4 edge (1-cycle latency).

Reset
REQ-032 rst==1 at rising edge: pc<=11'h7FF, stk1<=0, stk2<=0, stkDepth<=0, flushOut<=0, stkOvf<=0, stkUnf<=0.
REQ-033 rst SHALL override any phase/event in same cycle, including mid-instruction; first Q1 after release increments pc to 11'h000.
REQ-034 Block SHALL not depend on phase alignment at reset release; it acts purely on phase value each clock.

Verification
REQ-035 Reset, then 4 phases Q1..Q4 with instIn=NOP -> pcOut 7FF->000 after Q1, flushOut=0, stkDepth=0.
REQ-036 pc=0x005 after Q1, CALL 0x40, statusPA=2'b01 -> pc=0x240, stk1=0x005, stkDepth=1, flushOut=1 for next cycle; following RETLW -> pc=0x005, stkDepth=0.
REQ-037 Three CALLs back-to-back (each followed by flushed slot) -> stkDepth=2, stkOvf=1; two RETLWs return most recent two addresses, third RETLW -> stkUnf=1.
REQ-038 At Q4 with flushOut=1 present GOTO 0x1FF -> pc not loaded, flushOut clears; same GOTO next cycle with statusPA=2'b11 -> pc=0x7FF, then Q1 -> 0x000.
REQ-039 Same Q4: GOTO 0x010 with pclWrite=1, pclData=0xAA, skipReq=1 -> pc={statusPA,9'h010}, only GOTO effect applied.
REQ-040 skipReq=1 at Q4 of DECFSZ, pc=0x020 -> pc stays 0x020, flushOut=1 next cycle, back to 0 after following Q4; rst asserted during Q3 of flushed slot -> all REQ-032 values.
